// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a single outstanding request, a decode queue and redirect flush
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [XLEN-1:0]             imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [31:0]                 imem_rsp_data,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [31:0]                 dec_inst,
  output logic [XLEN-1:0]             dec_pc,
  output logic [$clog2(FQ_DEPTH):0]   fq_count,
  output logic                        misalign_err
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WAIT_DROP} state_t;

  state_t state, state_nx;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [XLEN-1:0] pc_q [FQ_DEPTH];
  logic [31:0] inst_q [FQ_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic outstanding, credit, accept, push, pop;

  // An in-flight request reserves a queue slot, so the queue can never overflow
  assign outstanding = state == WAIT || state == WAIT_DROP;
  assign credit = (fq_count + CW'(outstanding)) < CW'(FQ_DEPTH);
  assign accept = imem_req_valid && imem_req_ready;
  assign push = state == WAIT && imem_rsp_valid && !redirect_valid;
  assign pop = dec_valid && dec_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (nrst) state <= IDLE;
    else state <= state_nx;
  end

  // A redirect turns any request still owed a response into a dropped one
  always_comb begin
    state_nx = state;
    if (redirect_valid) state_nx = ((outstanding && !imem_rsp_valid) || accept) ? WAIT_DROP : REQ;
    else if (state == IDLE) state_nx = credit ? REQ : IDLE;
    else if (state == REQ) state_nx = imem_req_ready ? WAIT : REQ;
    else if (imem_rsp_valid) state_nx = credit ? REQ : IDLE;
  end

  always_comb begin
    imem_req_valid = state == REQ;
    imem_req_addr = imem_req_valid ? fetch_pc : '0;
    dec_valid = fq_count != '0;
    dec_pc = dec_valid ? pc_q[rd_ptr] : '0;
    dec_inst = dec_valid ? inst_q[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fq_count <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && |redirect_pc[1:0];
      if (redirect_valid) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      if (accept) req_pc <= fetch_pc;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        fq_count <= '0;
      end else begin
        rd_ptr <= rd_ptr + AW'(pop);
        wr_ptr <= wr_ptr + AW'(push);
        fq_count <= fq_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr] <= req_pc;
      inst_q[wr_ptr] <= imem_rsp_data;
    end
  end

  // Memory may only answer a request this block is waiting on
  assert property (@(posedge clk) disable iff (nrst) !imem_rsp_valid || outstanding);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a memory responder and a decode-side scoreboard
module tb_fetch_unit;
  logic clk = 1'b0;
  logic nrst;
  logic imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic dec_valid, dec_ready;
  logic [31:0] dec_inst, dec_pc;
  logic [2:0] fq_count;
  logic misalign_err;

  int n_chk = 0;
  int n_fail = 0;
  int rsp_lat = 1;
  int mcyc = 0;
  int req_cnt = 0;
  int base;
  logic [31:0] e_pc, e_inst;
  logic [31:0] exp_pc[$];
  logic [31:0] exp_inst[$];
  typedef struct packed {int due; logic [31:0] addr;} pend_t;
  pend_t pq[$];

  fetch_unit #(.XLEN(32), .RESET_PC(32'h100), .FQ_DEPTH(4)) dut (
    .clk(clk), .nrst(nrst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .fq_count(fq_count), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_pc.delete();
    exp_inst.delete();
    for (int i = 0; i < 32; i++) begin
      exp_pc.push_back(pc + 32'(4 * i));
      exp_inst.push_back(inst_of(pc + 32'(4 * i)));
    end
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    restart(32'h100);
    nrst = 1'b0;
  endtask

  // Memory: answers each accepted request rsp_lat cycles later
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (nrst) begin
        pq.delete();
        req_cnt = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
      end else if (pq.size() > 0 && pq[0].due <= mcyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = inst_of(pq[0].addr);
        void'(pq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
      end
      #2;
      if (!nrst && imem_req_valid && imem_req_ready) begin
        pq.push_back('{due: mcyc + rsp_lat, addr: imem_req_addr});
        req_cnt++;
      end
    end
  end

  // Scoreboard monitor: every pop decode performs must match the next expected entry
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!nrst && dec_valid && dec_ready && !redirect_valid) begin
        n_chk++;
        if (exp_pc.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: dec_pc %0h with nothing expected", dec_pc);
        end else begin
          e_pc = exp_pc.pop_front();
          e_inst = exp_inst.pop_front();
          if (dec_pc !== e_pc || dec_inst !== e_inst) begin
            n_fail++;
            $display("FAIL sb_pop: got pc %0h inst %0h expected pc %0h inst %0h", dec_pc, dec_inst, e_pc, e_inst);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b1;
    imem_req_ready = 1'b1;
    dec_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    // Reset state, then first-fetch latency and in-order delivery
    repeat (2) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_fq_count", fq_count, 0);
    chk("rst_misalign", misalign_err, 0);
    restart(32'h100);
    nrst = 1'b0;
    @(negedge clk); chk("t1_dv_clk1", dec_valid, 0);
    @(negedge clk); chk("t1_dv_clk2", dec_valid, 0);
    @(negedge clk); chk("t1_dv_clk3", dec_valid, 1);
    chk("t1_first_pc", dec_pc, 32'h100);
    repeat (12) @(negedge clk);
    // Stalled decode: exactly FQ_DEPTH requests, then one more per pop
    dec_ready = 1'b0;
    do_reset();
    repeat (30) @(negedge clk);
    chk("t2_req_cnt", req_cnt, 4);
    chk("t2_fq_full", fq_count, 4);
    chk("t2_req_idle", imem_req_valid, 0);
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_req_cnt_pop", req_cnt, 5);
    chk("t2_fq_refill", fq_count, 4);
    chk("t2_req_idle2", imem_req_valid, 0);
    dec_ready = 1'b1;
    repeat (20) @(negedge clk);
    // Backpressured request holds its address
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid && imem_req_addr == 32'h108) break;
      @(negedge clk);
    end
    imem_req_ready = 1'b0;
    chk("t3_found", {imem_req_valid, imem_req_addr}, {1'b1, 32'h108});
    base = req_cnt;
    repeat (4) begin
      @(negedge clk);
      chk("t3_hold", {imem_req_valid, imem_req_addr}, {1'b1, 32'h108});
    end
    @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("t3_accept", req_cnt, base + 1);
    repeat (10) @(negedge clk);
    // Redirect while waiting on a slow response
    rsp_lat = 3;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (imem_req_valid && imem_req_addr == 32'h10C) break;
      @(negedge clk);
    end
    chk("t4_found", {imem_req_valid, imem_req_addr}, {1'b1, 32'h10C});
    @(negedge clk);
    chk("t4_in_wait", imem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    @(negedge clk);
    redirect_valid = 1'b0;
    restart(32'h2000);
    chk("t4_fq_flush", fq_count, 0);
    chk("t4_dv_flush", dec_valid, 0);
    chk("t4_no_misalign", misalign_err, 0);
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) break;
      @(negedge clk);
    end
    chk("t4_new_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h2000});
    repeat (30) @(negedge clk);
    // Redirect coinciding with a pop and a response
    rsp_lat = 1;
    dec_ready = 1'b0;
    repeat (8) @(negedge clk);
    dec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (imem_rsp_valid && dec_valid) break;
    end
    chk("t5_found", {imem_rsp_valid, dec_valid}, 2'b11);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    @(negedge clk);
    redirect_valid = 1'b0;
    restart(32'h3000);
    chk("t5_fq_flush", fq_count, 0);
    chk("t5_dv_flush", dec_valid, 0);
    repeat (12) @(negedge clk);
    // Misaligned redirect and address wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'h2002;
    @(negedge clk);
    redirect_valid = 1'b0;
    restart(32'h2000);
    chk("t6_misalign_on", misalign_err, 1);
    chk("t6_fq_flush", fq_count, 0);
    @(negedge clk);
    chk("t6_misalign_off", misalign_err, 0);
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) break;
      @(negedge clk);
    end
    chk("t6_aligned_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h2000});
    repeat (8) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    restart(32'hFFFF_FFF8);
    chk("t6_wrap_no_misalign", misalign_err, 0);
    for (int i = 0; i < 30; i++) begin
      if (imem_req_valid && imem_req_addr == 32'h0) break;
      @(negedge clk);
    end
    chk("t6_wrap_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
